// File: rtl/kronos_types.sv
// Shared types and operand-signedness helpers for the Kronos iterative multiply/divide unit.
package kronos_types;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFixup,
        StDone
    } mdu_state_e;

    function automatic logic is_signed_op1(input mdu_op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic is_signed_op2(input mdu_op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/kronos_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one result bit per cycle, valid/ready on both sides,
// abortable by flush. Multiply and divide share one 2*XLEN accumulator and one XLEN+1 adder.
module kronos_mdu_iter
    import kronos_types::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    localparam int unsigned    CW      = $clog2(XLEN);
    localparam logic [CW-1:0]  CntLast = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mdu_op_e           op_q;
    logic              neg_q, sign1_q, dz_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_step;
    logic [XLEN-1:0]   result_q, result_d;

    // Request decode
    mdu_op_e         req_op_e;
    logic            s1, s2, op2_zero, ovf, special, accept;
    logic [XLEN-1:0] abs1, abs2, early_res;

    always_comb begin
        req_op_e  = mdu_op_e'(req_op);
        s1        = is_signed_op1(req_op_e) & req_op1[XLEN-1];
        s2        = is_signed_op2(req_op_e) & req_op2[XLEN-1];
        abs1      = s1 ? -req_op1 : req_op1;
        abs2      = s2 ? -req_op2 : req_op2;
        op2_zero  = (req_op2 == '0);
        ovf       = req_op[2] & ~req_op[0] & (req_op1 == MinNeg) & (&req_op2);
        special   = req_op[2] & (op2_zero | ovf);
        accept    = req_valid & req_ready;
        early_res = '0;
        if (op2_zero) begin
            early_res = req_op[1] ? req_op1 : '1;
        end else if (ovf) begin
            early_res = req_op[1] ? '0 : req_op1;
        end
    end

    // Shared datapath: shift-add for multiply, restoring subtract for divide
    logic [XLEN-1:0] hi, lo;
    logic [XLEN:0]   add_a, add_b, add_sum;
    logic            add_cin, no_borrow;

    always_comb begin
        hi = acc_q[2*XLEN-1:XLEN];
        lo = acc_q[XLEN-1:0];
        if (op_q[2]) begin
            add_a   = {hi, lo[XLEN-1]};
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, hi};
            add_b   = lo[0] ? {1'b0, opnd_q} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_a + add_b + (XLEN+1)'(add_cin);
        // Shifted remainder with its top bit set always exceeds the divisor
        no_borrow = add_a[XLEN] | ~add_sum[XLEN];
        if (op_q[2]) begin
            acc_step = {no_borrow ? add_sum[XLEN-1:0] : add_a[XLEN-1:0],
                        lo[XLEN-2:0], no_borrow};
        end else begin
            acc_step = {add_sum, lo[XLEN-1:1]};
        end
    end

    // Sign fixup and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        // A zero divisor yields all-ones regardless of dividend sign
        quo  = (neg_q & ~dz_q) ? -lo : lo;
        rem  = sign1_q ? -hi : hi;
        unique case (op_q)
            OpMul:                    fix_res = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_res = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:            fix_res = quo;
            default:                  fix_res = rem;
        endcase
    end

    always_comb begin
        result_d = result_q;
        if (accept && EARLY_OUT && special) begin
            result_d = early_res;
        end else if (state_q == StFixup && !flush) begin
            result_d = fix_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OpMul;
            neg_q    <= 1'b0;
            sign1_q  <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op_e;
                neg_q   <= s1 ^ s2;
                sign1_q <= s1;
                dz_q    <= op2_zero;
                opnd_q  <= req_op[2] ? abs2 : abs1;
                acc_q   <= {{XLEN{1'b0}}, req_op[2] ? abs1 : abs2};
            end else if (state_q == StCalc) begin
                acc_q <= acc_step;
            end
            result_q <= result_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (EARLY_OUT && special) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StFixup;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFixup: state_d = StDone;
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // FSM: outputs
    always_comb begin
        req_ready = (state_q == StIdle) & ~flush;
        busy      = (state_q != StIdle);
        rsp_valid = (state_q == StDone);
    end

    assign rsp_result = result_q;

endmodule

// File: doc/kronos_mdu_iter.md
Name: kronos_mdu_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set, at one result bit per cycle.
- Sits beside the single-cycle ALU in the execute stage.
- Execute hands over operands through a valid/ready request and collects the result through a valid/ready response.
- An in-flight operation can be aborted by flush.

Parameters:
- XLEN, 32: operand and result width; any even value ≥ 8.
- EARLY_OUT, 1: when 1, divide-by-zero and signed-overflow cases bypass iteration and respond 1 cycle after accept.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  abort the current operation; no response is produced
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state==IDLE) & ~flush
- req_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_op1  in  XLEN  rs1 value (multiplicand/dividend)
- req_op2  in  XLEN  rs2 value (multiplier/divisor)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_result  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset values (async on rst high): state IDLE; rsp_valid 0; rsp_result 0; busy 0; iteration counter 0.
- Accept: at a rising edge with req_valid & req_ready, the unit latches op, operand signs and absolute values.
  - op1 is signed for MUL, MULH, MULHSU, DIV, REM.
  - op2 is signed for MUL, MULH, DIV, REM.
  - Unsigned operands pass through unchanged.
- States:
  - IDLE: on accept, go to DONE if EARLY_OUT and a special case applies, else to CALC.
  - CALC: one iteration per cycle, counter 0..XLEN-1. After iteration XLEN-1, go to FIXUP.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring division, XLEN-bit partial remainder, quotient shifted in LSB-first.
  - FIXUP: apply sign correction, select the result half, load rsp_result, go to DONE.
    - Product negated if sign1^sign2.
    - Quotient negated if sign1^sign2.
    - Remainder takes the dividend sign.
  - DONE: rsp_valid=1 with rsp_result held stable until rsp_ready; go to IDLE on the edge where rsp_ready=1.
- Latency: rsp_valid rises XLEN+2 cycles after the accept edge (1 into CALC, XLEN iterations, 1 FIXUP). Special cases take 1 cycle.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2XLEN-1:XLEN].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, which must match RISC-V regardless of EARLY_OUT:
  - Divisor 0: quotient all-ones; remainder = op1.
  - Signed overflow (op1 = most-negative, op2 = -1, DIV/REM): quotient = op1; remainder = 0.
- No back-to-back throughput: req_ready is low in CALC, FIXUP and DONE. A new request can be accepted the cycle after the DONE handshake.
- Flush:
  - In any state, the next edge goes to IDLE, clears rsp_valid and zeroes the counter. No response is emitted.
  - Flush with rsp_valid&rsp_ready on the same edge: flush wins; the consumer must treat the result as dropped.
  - Flush in IDLE with req_valid: request not accepted, because req_ready is gated.
- rst mid-operation: immediate return to the reset values, with no response.
- Arithmetic is modulo 2^XLEN for results; internal sums are XLEN+1 bits wide so no carry is lost.

Decomposition:
- kronos_types package: mdu_op_e enum (the 8 funct3 encodings above) and mdu_state_e enum (IDLE, CALC, FIXUP, DONE).
- Helper functions is_signed_op1/is_signed_op2 in the package.
- No sub-module. The shift-add and restoring-divide datapaths share one accumulator and one XLEN+1 adder inside this module.

Test Plan:
- MULH 0x80000000 × 0x80000000 -> 0x40000000; rsp_valid exactly 34 cycles after accept (XLEN=32).
- MULHSU op1=0xFFFFFFFF (-1), op2=0xFFFFFFFF -> 0xFFFFFFFF; MUL of the same operands -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 7/2 -> 3; REMU 7%2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000 % 0xFFFFFFFF -> 0; DIV of the same -> 0x80000000. With EARLY_OUT=1 each responds 1 cycle after accept.
- Flush pulsed in CALC at iteration 10 -> no rsp_valid; req_ready high next cycle; following MUL 3×4 -> 12 correct.
- Backpressure: hold rsp_ready low 5 cycles in DONE -> rsp_result stable, req_ready low; assert rsp_ready -> IDLE next edge. Async rst mid-CALC -> all outputs 0 immediately.
